// File: rtl/guess_scorer.sv
// -----------------------------------------------------------------------------
// guess_scorer
//   Scores one committed guess against the secret word with exact Wordle rules
//   (green pass first, then a yellow pass that consumes each secret letter at
//   most once) and streams one colour per tile into the colour store through a
//   single write port. Also sequences a full-board clear.
//
// Ports
//   Clk       in   system clock, all state on posedge
//   reset_n   in   asynchronous active-low reset
//   Start     in   1-cycle request: score guess into row_in
//   Clear     in   1-cycle request: blank every tile (wins over Start)
//   row_in    in   target row for Start
//   guess     in   guess word, letter 0 in the top byte
//   secret    in   secret word, same packing
//   busy      out  operation in progress (cycle after acceptance until done)
//   done      out  1-cycle completion pulse
//   win       out  every tile of the last scored guess was green
//   err       out  last Start named a row outside the board
//   wr_en     out  colour write strobe
//   wr_row    out  write row
//   wr_col    out  write column
//   wr_color  out  write data {R,G,B}
// -----------------------------------------------------------------------------
module guess_scorer #(
    parameter int         NUM_ROWS = 6,
    parameter int         WORD_LEN = 5,
    parameter int         LETTER_W = 8,
    parameter logic [2:0] C_GREEN  = 3'b010,
    parameter logic [2:0] C_YELLOW = 3'b110,
    parameter logic [2:0] C_WHITE  = 3'b111,
    parameter logic [2:0] C_BLANK  = 3'b000
) (
    input  logic                         Clk,
    input  logic                         reset_n,
    input  logic                         Start,
    input  logic                         Clear,
    input  logic [2:0]                   row_in,
    input  logic [WORD_LEN*LETTER_W-1:0] guess,
    input  logic [WORD_LEN*LETTER_W-1:0] secret,
    output logic                         busy,
    output logic                         done,
    output logic                         win,
    output logic                         err,
    output logic                         wr_en,
    output logic [2:0]                   wr_row,
    output logic [2:0]                   wr_col,
    output logic [2:0]                   wr_color
);

    localparam int         WORD_BITS = WORD_LEN * LETTER_W;
    localparam logic [2:0] LAST_COL  = 3'(WORD_LEN - 1);
    localparam logic [2:0] COL_END   = 3'(WORD_LEN);   // one past the last column
    localparam logic [2:0] ROW_END   = 3'(NUM_ROWS);   // one past the last row

    typedef enum logic [2:0] {
        S_IDLE, S_GREEN, S_YELLOW, S_WRITE, S_CLR, S_DONE
    } state_t;

    state_t                 state, state_next;
    logic [WORD_BITS-1:0]   guess_q, secret_q;
    logic [2:0]             row_q;      // latched score row
    logic [2:0]             col_q;      // column walker shared by every pass
    logic [2:0]             clr_row_q;  // row walker for the clear sweep
    logic                   op_clear;   // current operation is a clear
    logic [WORD_LEN-1:0]    green, yellow, consumed;

    logic                   yel_found;
    logic [2:0]             yel_idx;

    function automatic logic [LETTER_W-1:0] letter_at(input logic [WORD_BITS-1:0] w,
                                                      input int idx);
        return w[(WORD_LEN - 1 - idx) * LETTER_W +: LETTER_W];
    endfunction

    // Lowest unconsumed secret position holding the current guess letter.
    // Walking downward lets the lowest match overwrite any higher one.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        yel_found = 1'b0;
        yel_idx   = '0;
        for (int j = WORD_LEN - 1; j >= 0; j--) begin
            if (!consumed[j] && letter_at(secret_q, j) == letter_at(guess_q, int'(col_q))) begin
                yel_found = 1'b1;
                yel_idx   = 3'(j);
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (Clear)                state_next = S_CLR;
                      else if (Start)           state_next = S_GREEN;
            S_GREEN:  if (err)                  state_next = S_DONE;
                      else if (col_q == LAST_COL) state_next = S_YELLOW;
            S_YELLOW: if (col_q == LAST_COL)    state_next = S_WRITE;
            S_WRITE:  if (col_q == COL_END)     state_next = S_DONE;
            S_CLR:    if (clr_row_q == ROW_END) state_next = S_DONE;
            S_DONE:                             state_next = S_IDLE;
            default:                            state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            guess_q   <= '0;
            secret_q  <= '0;
            row_q     <= '0;
            col_q     <= '0;
            clr_row_q <= '0;
            op_clear  <= 1'b0;
            green     <= '0;
            yellow    <= '0;
            consumed  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            win       <= 1'b0;
            err       <= 1'b0;
            wr_en     <= 1'b0;
            wr_row    <= '0;
            wr_col    <= '0;
            wr_color  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            done  <= 1'b0;
            wr_en <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (Clear) begin
                        busy      <= 1'b1;
                        op_clear  <= 1'b1;
                        col_q     <= '0;
                        clr_row_q <= '0;
                    end else if (Start) begin
                        busy     <= 1'b1;
                        op_clear <= 1'b0;
                        guess_q  <= guess;
                        secret_q <= secret;
                        row_q    <= row_in;
                        col_q    <= '0;
                        green    <= '0;
                        yellow   <= '0;
                        consumed <= '0;
                        win      <= 1'b0;
                        err      <= (row_in >= ROW_END);
                    end
                end
                S_GREEN: begin
                    if (!err) begin
                        if (letter_at(guess_q, int'(col_q)) == letter_at(secret_q, int'(col_q))) begin
                            green[col_q]    <= 1'b1;
                            consumed[col_q] <= 1'b1;
                        end
                        col_q <= (col_q == LAST_COL) ? 3'd0 : col_q + 3'd1;
                    end
                end
                S_YELLOW: begin
                    if (!green[col_q] && yel_found) begin
                        yellow[col_q]     <= 1'b1;
                        consumed[yel_idx] <= 1'b1;
                    end
                    col_q <= (col_q == LAST_COL) ? 3'd0 : col_q + 3'd1;
                end
                S_WRITE: begin
                    // The cycle with col_q == COL_END is the idle gap before DONE.
                    if (col_q != COL_END) begin
                        wr_en    <= 1'b1;
                        wr_row   <= row_q;
                        wr_col   <= col_q;
                        wr_color <= green[col_q]  ? C_GREEN  :
                                    yellow[col_q] ? C_YELLOW : C_WHITE;
                        col_q    <= col_q + 3'd1;
                    end
                end
                S_CLR: begin
                    if (clr_row_q != ROW_END) begin
                        wr_en    <= 1'b1;
                        wr_row   <= clr_row_q;
                        wr_col   <= col_q;
                        wr_color <= C_BLANK;
                        if (col_q == LAST_COL) begin
                            col_q     <= '0;
                            clr_row_q <= clr_row_q + 3'd1;
                        end else begin
                            col_q <= col_q + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (op_clear) begin
                        win <= 1'b0;
                        err <= 1'b0;
                    end else begin
                        win <= &green;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_guess_scorer.sv
// Self-checking bench for guess_scorer: directed table, hand-written corner
// sequences and random guesses compared with a letter-count Wordle model.
module tb_guess_scorer;

    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Start = 1'b0;
    logic        Clear = 1'b0;
    logic [2:0]  row_in = '0;
    logic [39:0] guess = '0;
    logic [39:0] secret = '0;
    logic        busy, done, win, err, wr_en;
    logic [2:0]  wr_row, wr_col, wr_color;

    guess_scorer dut (
        .Clk(Clk), .reset_n(reset_n), .Start(Start), .Clear(Clear),
        .row_in(row_in), .guess(guess), .secret(secret),
        .busy(busy), .done(done), .win(win), .err(err),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_color(wr_color)
    );

    always #5 Clk = ~Clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Observed behaviour of the last operation, n = cycles after the accepting edge.
    int         w_n[$];
    logic [2:0] w_row[$], w_col[$], w_color[$];
    int         done_n, done_cnt;
    logic       busy0, done_win, done_err, busy_end;

    task automatic run_op(input logic st, input logic cl, input logic [2:0] r,
                          input logic [39:0] g, input logic [39:0] s, input int poke_at);
        w_n.delete(); w_row.delete(); w_col.delete(); w_color.delete();
        done_n = -1; done_cnt = 0; done_win = 1'b0; done_err = 1'b0;
        @(negedge Clk);
        Start = st; Clear = cl; row_in = r; guess = g; secret = s;
        @(negedge Clk);
        // Scramble inputs to prove they were latched.
        Start = 1'b0; Clear = 1'b0; row_in = ~r; guess = ~g; secret = ~s;
        busy0 = busy;
        for (int n = 1; n <= 60; n++) begin
            @(negedge Clk);
            if (wr_en) begin
                w_n.push_back(n); w_row.push_back(wr_row);
                w_col.push_back(wr_col); w_color.push_back(wr_color);
            end
            if (done) begin
                done_cnt++;
                if (done_n < 0) begin
                    done_n = n; done_win = win; done_err = err;
                end
            end
            Start = (n == poke_at);
            if (n == poke_at) row_in = 3'd1;
            if (done_n >= 0 && n >= done_n + 3) break;
        end
        Start = 1'b0;
        busy_end = busy;
        if (done_n < 0) check("done_timeout", 0, 1);
    endtask

    // Wordle reference: greens first, then yellows drawn from a per-letter
    // count of the secret letters that were not matched green.
    function automatic logic [14:0] model_colors(input logic [39:0] g, input logic [39:0] s);
        int         cnt[256];
        logic [7:0] gl[5], sl[5];
        logic       is_g[5];
        logic [14:0] res = '0;
        foreach (cnt[i]) cnt[i] = 0;
        for (int i = 0; i < 5; i++) begin
            gl[i] = g[39 - 8*i -: 8];
            sl[i] = s[39 - 8*i -: 8];
            is_g[i] = (gl[i] == sl[i]);
            if (!is_g[i]) cnt[sl[i]]++;
        end
        for (int i = 0; i < 5; i++) begin
            if (is_g[i])               res[14 - 3*i -: 3] = 3'b010;
            else if (cnt[gl[i]] > 0) begin
                res[14 - 3*i -: 3] = 3'b110;
                cnt[gl[i]]--;
            end else                   res[14 - 3*i -: 3] = 3'b111;
        end
        return res;
    endfunction

    task automatic check_score(input string name, input logic [2:0] r, input logic [39:0] g,
                               input logic [39:0] s, input logic [14:0] exp_col,
                               input logic exp_win, input int poke_at);
        run_op(1'b1, 1'b0, r, g, s, poke_at);
        check({name, ".busy"}, busy0, 1);
        check({name, ".done_cnt"}, done_cnt, 1);
        check({name, ".busy_end"}, busy_end, 0);
        if (r >= 3'd6) begin
            check({name, ".nwrites"}, w_n.size(), 0);
            check({name, ".done_n"}, done_n, 2);
            check({name, ".err"}, done_err, 1);
            check({name, ".win"}, done_win, 0);
        end else begin
            check({name, ".nwrites"}, w_n.size(), 5);
            for (int i = 0; i < 5 && i < w_n.size(); i++) begin
                check($sformatf("%s.w%0d_n", name, i), w_n[i], 11 + i);
                check($sformatf("%s.w%0d_row", name, i), w_row[i], r);
                check($sformatf("%s.w%0d_col", name, i), w_col[i], i);
                check($sformatf("%s.w%0d_color", name, i), w_color[i], exp_col[14 - 3*i -: 3]);
            end
            check({name, ".done_n"}, done_n, 17);
            check({name, ".err"}, done_err, 0);
            check({name, ".win"}, done_win, exp_win);
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  row;
        logic [39:0] secret;
        logic [39:0] guess;
        logic [14:0] exp_col;
        logic        exp_win;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"crane", 3'd0, "CRANE", "CRANE", {3'b010,3'b010,3'b010,3'b010,3'b010}, 1'b1};
        vecs[1] = '{"apple", 3'd2, "APPLE", "PAPER", {3'b110,3'b110,3'b010,3'b110,3'b111}, 1'b0};
        vecs[2] = '{"abbey", 3'd5, "ABBEY", "BBBBB", {3'b111,3'b010,3'b010,3'b111,3'b111}, 1'b0};
        vecs[3] = '{"speed", 3'd3, "SPEED", "EERIE", {3'b110,3'b110,3'b111,3'b111,3'b111}, 1'b0};
        vecs[4] = '{"badrow", 3'd6, "CRANE", "CRANE", 15'd0, 1'b0};

        // Reset state
        #12;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.win", win, 0);
        check("rst.err", err, 0);
        check("rst.wr_en", wr_en, 0);
        check("rst.wr_bus", {wr_row, wr_col, wr_color}, 0);
        @(negedge Clk);
        reset_n = 1'b1;

        foreach (vecs[i])
            check_score(vecs[i].name, vecs[i].row, vecs[i].guess, vecs[i].secret,
                        vecs[i].exp_col, vecs[i].exp_win, 0);

        // Start while busy is ignored: a second Start in GREEN must not retarget the row
        check_score("busy_start", 3'd4, "APPLE", "APPLE", {5{3'b010}}, 1'b1, 3);

        // Clear wins over simultaneous Start
        run_op(1'b1, 1'b1, 3'd1, "CRANE", "CRANE", 0);
        check("clr.nwrites", w_n.size(), 30);
        for (int i = 0; i < 30 && i < w_n.size(); i++) begin
            check($sformatf("clr.w%0d_n", i), w_n[i], 1 + i);
            check($sformatf("clr.w%0d_pos", i), {w_row[i], w_col[i]}, {3'(i / 5), 3'(i % 5)});
            check($sformatf("clr.w%0d_color", i), w_color[i], 0);
        end
        check("clr.done_n", done_n, 32);
        check("clr.win", done_win, 0);
        check("clr.err", done_err, 0);

        // Reset in the middle of the yellow pass
        @(negedge Clk);
        Start = 1'b1; row_in = 3'd3; guess = "PAPER"; secret = "APPLE";
        @(negedge Clk);
        Start = 1'b0;
        repeat (7) @(negedge Clk);
        check("midrst.busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check("midrst.busy", busy, 0);
        check("midrst.wr_en", wr_en, 0);
        check("midrst.done", done, 0);
        @(negedge Clk);
        reset_n = 1'b1;
        check_score("after_rst", 3'd3, "PAPER", "APPLE", model_colors("PAPER", "APPLE"), 1'b0, 0);

        // Random guesses over a small alphabet so duplicates are common
        for (int t = 0; t < 30; t++) begin
            logic [39:0] g, s;
            logic [2:0]  r;
            for (int i = 0; i < 5; i++) begin
                g[39 - 8*i -: 8] = 8'h41 + 8'($urandom_range(0, 2));
                s[39 - 8*i -: 8] = 8'h41 + 8'($urandom_range(0, 2));
            end
            if (t % 7 == 0) g = s;
            r = 3'($urandom_range(0, 6));
            check_score($sformatf("rnd%0d", t), r, g, s, model_colors(g, s), (g == s), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
